nmr_bstrm_seq: RTL and testbench
================================

NMR_BSTRM_SEQ -- requirements
Module: nmr_bstrm_seq

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of the bitstream data field driven to the GPIO.
REQ-002 Parameter CNT_WIDTH, default 15: width of the per-word dwell-count field.
REQ-003 Parameter IDLE_WORD, default 0: value driven on bitstr_out whenever no word is being played.
REQ-004 Parameter WCNT_WIDTH, default 16: width of the played-word counter.
REQ-005 Word layout, BUS_WIDTH = DATA_WIDTH+CNT_WIDTH+1: [MSB] = D_END, [MSB-1 -: CNT_WIDTH] = dwell, [DATA_WIDTH-1:0] = data.
REQ-006 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-007 CLK  in  1  system clock.
REQ-008 RST_n  in  1  asynchronous active-low reset.
REQ-009 START  in  1  level from the SoC that arms the sequence.
REQ-010 STOP  in  1  level from the SoC that ends or aborts the sequence.
REQ-011 fifo_data  in  BUS_WIDTH  show-ahead FIFO head word.
REQ-012 fifo_empty  in  1  FIFO empty flag.
REQ-013 fifo_rd  out  1  pop strobe, one cycle per word consumed.
REQ-014 bitstr_out  out  DATA_WIDTH  registered GPIO bitstream.
REQ-015 D_END  out  1  registered sequence-done flag to the SoC.
REQ-016 busy  out  1  high in ARM or RUN.
REQ-017 words_played  out  WCNT_WIDTH  count of words popped since the last arm.

Function
REQ-018 States: IDLE, ARM, RUN, DONE, REL; one-hot encoding.
REQ-019 IDLE: bitstr_out=IDLE_WORD and D_END=0; START=1 moves to ARM, clears words_played, and clears the underflow flag.
REQ-020 ARM: with fifo_empty=0, assert fifo_rd combinationally, register data into bitstr_out, dwell into the counter and D_END into end_r, then move to RUN; with fifo_empty=1, stay in ARM.
REQ-021 RUN: each word is held for dwell+1 cycles; the counter decrements each cycle while nonzero.
REQ-022 RUN, counter=0 and end_r=0 and fifo_empty=0: pop and load the next word on the same edge, giving gapless playback with zero idle cycles between words.
REQ-023 RUN, counter=0 and end_r=1: go to DONE, with bitstr_out=IDLE_WORD and D_END=1 from the next cycle.
REQ-024 RUN, counter=0 and end_r=0 and fifo_empty=1 (underflow): hold the last data and stay in RUN until a word arrives.
REQ-025 DONE: hold IDLE_WORD and D_END=1; STOP=1 moves to REL.
REQ-026 STOP=1 in ARM or RUN aborts: next cycle bitstr_out=IDLE_WORD, state=REL, D_END=0, no further pops.
REQ-027 REL: D_END=0, bitstr_out=IDLE_WORD; START=0 moves to IDLE. START and STOP both high in IDLE are ignored until START falls.
REQ-028 words_played increments on each fifo_rd and saturates at all-ones.
REQ-029 fifo_rd SHALL never assert when fifo_empty=1 or outside ARM/RUN.
REQ-030 D_END is registered, so a stale end flag from the prior sequence SHALL never be visible after START.

Reset
REQ-031 RST_n low, asynchronously: state=IDLE, bitstr_out=IDLE_WORD, D_END=0, fifo_rd=0, busy=0, counter=0, words_played=0, underflow flag=0.
REQ-032 Reset mid-RUN SHALL drop the current word immediately without popping; the FIFO is not flushed.

Configuration
REQ-033 Macro NMR_BSTRM_UFLOW_EN defined: add output ufl (1 bit), set sticky on any REQ-024 underflow cycle and cleared only by reset or by the IDLE-to-ARM transition.
REQ-034 Macro NMR_BSTRM_UFLOW_EN undefined: no ufl port and no flag logic; underflow behaviour per REQ-024 is unchanged.

Structure
REQ-035 Package nmr_bstrm_pkg: state encoding localparams, word-field offset functions of DATA_WIDTH/CNT_WIDTH.
REQ-036 Sub-module nmr_bstrm_dwell_cnt: loadable down-counter with a zero flag, instantiated once.

Verification
REQ-037 Run three words, dwells 2/0/3, third with D_END -> data held 3/1/4 cycles back-to-back; D_END=1 on cycle 9 after the first load; words_played=3.
REQ-038 START with the FIFO empty for 5 cycles, then a push -> ARM held, fifo_rd=0 throughout, first pop on the cycle after fifo_empty falls.
REQ-039 Empty the FIFO after word 1 (dwell 0) for 4 cycles -> bitstr_out holds word 1 data for 5 cycles; ufl=1 when macro defined.
REQ-040 STOP mid-dwell (dwell 100, cycle 10) -> IDLE_WORD next cycle, state REL, D_END=0, no pop; START low -> IDLE.
REQ-041 RST_n low during RUN -> all outputs at reset values within the same cycle; after re-arm, words_played restarts at 0.

Source files
------------

// File: rtl/nmr_bstrm_pkg.sv
// nmr_bstrm_pkg: shared state encoding and word-field offsets for the
// NMR bitstream sequencer.
package nmr_bstrm_pkg;

    // One-hot state encoding
    localparam logic [4:0] ST_IDLE = 5'b00001;
    localparam logic [4:0] ST_ARM  = 5'b00010;
    localparam logic [4:0] ST_RUN  = 5'b00100;
    localparam logic [4:0] ST_DONE = 5'b01000;
    localparam logic [4:0] ST_REL  = 5'b10000;

    // Total FIFO word width: end flag + dwell + data
    function automatic int bus_width(input int dw, input int cw);
        return dw + cw + 1;
    endfunction

    // LSB of the dwell field inside a FIFO word
    function automatic int cnt_lsb(input int dw);
        return dw;
    endfunction

    // Bit position of the end-of-sequence flag (word MSB)
    function automatic int end_bit(input int dw, input int cw);
        return dw + cw;
    endfunction

endpackage

// File: rtl/nmr_bstrm_dwell_cnt.sv
// nmr_bstrm_dwell_cnt: loadable down-counter that stops at zero and
// reports when it has reached zero. Load wins over decrement; clear wins
// over load.
module nmr_bstrm_dwell_cnt #(
    parameter int CNT_WIDTH = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 clr,
    input  logic [CNT_WIDTH-1:0] load_val,
    output logic                 zero
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    // Next count: clear, load, or decrement while nonzero
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/nmr_bstrm_seq.sv
// nmr_bstrm_seq: plays words from a show-ahead FIFO onto a GPIO
// bitstream, holding each word for dwell+1 cycles, gapless between words.
// Optional feature: define NMR_BSTRM_UFLOW_EN to add the sticky `ufl`
// underflow output.
//
// state | meaning
// IDLE  | outputs idle, waiting for START to arm
// ARM   | armed, waiting for the first FIFO word
// RUN   | playing words; holds last data on FIFO underflow
// DONE  | end word finished, D_END high until STOP
// REL   | released/aborted, waiting for START to fall
module nmr_bstrm_seq
    import nmr_bstrm_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 15,
    parameter logic [DATA_WIDTH-1:0] IDLE_WORD = '0,
    parameter int WCNT_WIDTH = 16
) (
    input  logic                                           CLK,
    input  logic                                           RST_n,
    input  logic                                           START,
    input  logic                                           STOP,
    input  logic [bus_width(DATA_WIDTH, CNT_WIDTH)-1:0]    fifo_data,
    input  logic                                           fifo_empty,
    output logic                                           fifo_rd,
    output logic [DATA_WIDTH-1:0]                          bitstr_out,
    output logic                                           D_END,
    output logic                                           busy,
    output logic [WCNT_WIDTH-1:0]                          words_played
`ifdef NMR_BSTRM_UFLOW_EN
   ,output logic                                           ufl
`endif
);

    localparam int CNT_LSB = cnt_lsb(DATA_WIDTH);
    localparam int END_BIT = end_bit(DATA_WIDTH, CNT_WIDTH);

    logic [4:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] bitstr_q, bitstr_d;
    logic                  d_end_q, d_end_d;
    logic                  end_q, end_d;
    logic [WCNT_WIDTH-1:0] words_q, words_d;
    logic                  words_clr;
    logic                  pop;
    logic                  cnt_clr;
    logic                  cnt_zero;

    nmr_bstrm_dwell_cnt #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_dwell_cnt (
        .clk      (CLK),
        .rst_n    (RST_n),
        .load     (pop),
        .clr      (cnt_clr),
        .load_val (fifo_data[CNT_LSB +: CNT_WIDTH]),
        .zero     (cnt_zero)
    );

    // Sequencer next-state, pop decision and registered-output next values
    always_comb begin
        state_d   = state_q;
        bitstr_d  = bitstr_q;
        d_end_d   = 1'b0;
        end_d     = end_q;
        words_clr = 1'b0;
        pop       = 1'b0;
        cnt_clr   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bitstr_d = IDLE_WORD;
                // START with STOP parks in REL so nothing arms until START falls
                if (START && STOP) begin
                    state_d = ST_REL;
                end else if (START) begin
                    state_d   = ST_ARM;
                    words_clr = 1'b1;
                end
            end
            ST_ARM: begin
                if (STOP) begin
                    state_d  = ST_REL;
                    bitstr_d = IDLE_WORD;
                    cnt_clr  = 1'b1;
                end else if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (STOP) begin
                    state_d  = ST_REL;
                    bitstr_d = IDLE_WORD;
                    cnt_clr  = 1'b1;
                end else if (cnt_zero) begin
                    if (end_q) begin
                        state_d  = ST_DONE;
                        bitstr_d = IDLE_WORD;
                        d_end_d  = 1'b1;
                    end else if (!fifo_empty) begin
                        pop = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                bitstr_d = IDLE_WORD;
                if (STOP) begin
                    state_d = ST_REL;
                end else begin
                    d_end_d = 1'b1;
                end
            end
            ST_REL: begin
                bitstr_d = IDLE_WORD;
                if (!START) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                bitstr_d = IDLE_WORD;
            end
        endcase

        if (pop) begin
            bitstr_d = fifo_data[DATA_WIDTH-1:0];
            end_d    = fifo_data[END_BIT];
        end

        words_d = words_q;
        if (words_clr) begin
            words_d = '0;
        end else if (pop && (words_q != '1)) begin
            words_d = words_q + WCNT_WIDTH'(1);
        end
    end

    // Sequencer state and registered outputs
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q  <= ST_IDLE;
            bitstr_q <= IDLE_WORD;
            d_end_q  <= 1'b0;
            end_q    <= 1'b0;
            words_q  <= '0;
        end else begin
            state_q  <= state_d;
            bitstr_q <= bitstr_d;
            d_end_q  <= d_end_d;
            end_q    <= end_d;
            words_q  <= words_d;
        end
    end

`ifdef NMR_BSTRM_UFLOW_EN
    logic ufl_q, ufl_d;
    logic uflow;

    // Underflow: word expired, no end flag, nothing waiting in the FIFO
    always_comb begin
        uflow = (state_q == ST_RUN) && !STOP && cnt_zero && !end_q && fifo_empty;
        ufl_d = ufl_q;
        if (words_clr) begin
            ufl_d = 1'b0;
        end else if (uflow) begin
            ufl_d = 1'b1;
        end
    end

    // Sticky underflow flag
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            ufl_q <= 1'b0;
        end else begin
            ufl_q <= ufl_d;
        end
    end

    assign ufl = ufl_q;
`endif

    assign fifo_rd      = pop;
    assign bitstr_out   = bitstr_q;
    assign D_END        = d_end_q;
    assign busy         = (state_q == ST_ARM) || (state_q == ST_RUN);
    assign words_played = words_q;

endmodule

// File: tb/tb_nmr_bstrm_seq.sv
// tb_nmr_bstrm_seq: directed bench for nmr_bstrm_seq with a small
// show-ahead FIFO model. Build with NMR_BSTRM_UFLOW_EN to also check ufl.
module tb_nmr_bstrm_seq;

    localparam logic [15:0] IDLE_W = 16'hA5A5;

    logic        CLK = 1'b0;
    logic        RST_n;
    logic        START;
    logic        STOP;
    logic [31:0] fifo_data;
    logic        fifo_empty;
    logic        fifo_rd;
    logic [15:0] bitstr_out;
    logic        D_END;
    logic        busy;
    logic [15:0] words_played;
`ifdef NMR_BSTRM_UFLOW_EN
    logic        ufl;
`endif

    int n_checks = 0;
    int n_err    = 0;
    int bad_pops = 0;

    logic [31:0] mem [0:15];
    int          wr_ptr = 0;
    int          rd_ptr = 0;

    always #5 CLK = ~CLK;

    nmr_bstrm_seq #(
        .DATA_WIDTH (16),
        .CNT_WIDTH  (15),
        .IDLE_WORD  (IDLE_W),
        .WCNT_WIDTH (16)
    ) dut (
        .CLK          (CLK),
        .RST_n        (RST_n),
        .START        (START),
        .STOP         (STOP),
        .fifo_data    (fifo_data),
        .fifo_empty   (fifo_empty),
        .fifo_rd      (fifo_rd),
        .bitstr_out   (bitstr_out),
        .D_END        (D_END),
        .busy         (busy),
        .words_played (words_played)
`ifdef NMR_BSTRM_UFLOW_EN
       ,.ufl          (ufl)
`endif
    );

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_data  = mem[rd_ptr[3:0]];

    // FIFO pop on the read strobe; any strobe while empty is illegal
    always @(posedge CLK) begin
        if (fifo_rd) begin
            if (fifo_empty) bad_pops <= bad_pops + 1;
            else            rd_ptr   <= rd_ptr + 1;
        end
    end

    function automatic logic [31:0] mk(input logic e, input logic [14:0] d, input logic [15:0] v);
        return {e, d, v};
    endfunction

    task automatic push(input logic [31:0] w);
        mem[wr_ptr[3:0]] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // From DONE: STOP releases, D_END drops, START low returns to IDLE
    task automatic release_seq(input string tag);
        STOP  = 1'b1;
        START = 1'b0;
        @(negedge CLK); #1;
        chk({tag, "_rel_dend"}, 32'(D_END), 32'd0);
        chk({tag, "_rel_bits"}, 32'(bitstr_out), 32'(IDLE_W));
        STOP = 1'b0;
        @(negedge CLK); #1;
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    logic [15:0] exp_bits [1:9];
    logic        exp_rd   [1:9];

    initial begin
        RST_n = 1'b0;
        START = 1'b0;
        STOP  = 1'b0;
        @(negedge CLK);
        @(negedge CLK); #1;
        chk("rst_bits",  32'(bitstr_out),   32'(IDLE_W));
        chk("rst_dend",  32'(D_END),        32'd0);
        chk("rst_busy",  32'(busy),         32'd0);
        chk("rst_rd",    32'(fifo_rd),      32'd0);
        chk("rst_words", 32'(words_played), 32'd0);

        // Three words, dwells 2/0/3, last carries end flag
        exp_bits = '{16'h1111, 16'h1111, 16'h1111, 16'h2222,
                     16'h3333, 16'h3333, 16'h3333, 16'h3333, IDLE_W};
        exp_rd   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        @(negedge CLK);
        RST_n = 1'b1;
        push(mk(1'b0, 15'd2, 16'h1111));
        push(mk(1'b0, 15'd0, 16'h2222));
        push(mk(1'b1, 15'd3, 16'h3333));
        START = 1'b1;
        @(negedge CLK); #1;
        chk("t1_arm_rd",   32'(fifo_rd), 32'd1);
        chk("t1_arm_busy", 32'(busy),    32'd1);
        for (int c = 1; c <= 9; c++) begin
            @(negedge CLK); #1;
            chk($sformatf("t1_bits_c%0d", c), 32'(bitstr_out), 32'(exp_bits[c]));
            chk($sformatf("t1_rd_c%0d", c),   32'(fifo_rd),    32'(exp_rd[c]));
            chk($sformatf("t1_dend_c%0d", c), 32'(D_END),      (c == 9) ? 32'd1 : 32'd0);
        end
        chk("t1_words", 32'(words_played), 32'd3);
        chk("t1_busy",  32'(busy),         32'd0);
        release_seq("t1");

        // Arm with FIFO empty for 5 cycles, then one end word
        START = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge CLK); #1;
            chk($sformatf("t2_wait_rd_c%0d", c),   32'(fifo_rd), 32'd0);
            chk($sformatf("t2_wait_busy_c%0d", c), 32'(busy),    32'd1);
        end
        @(negedge CLK);
        push(mk(1'b1, 15'd0, 16'h4444));
        #1;
        chk("t2_first_rd", 32'(fifo_rd), 32'd1);
        @(negedge CLK); #1;
        chk("t2_bits",  32'(bitstr_out),   32'h4444);
        chk("t2_words", 32'(words_played), 32'd1);
        @(negedge CLK); #1;
        chk("t2_dend",  32'(D_END),        32'd1);
        chk("t2_idle",  32'(bitstr_out),   32'(IDLE_W));
        release_seq("t2");

        // Underflow after word 1 (dwell 0) for 4 cycles
        push(mk(1'b0, 15'd0, 16'h5555));
        START = 1'b1;
        @(negedge CLK); #1;
        chk("t3_arm_rd", 32'(fifo_rd), 32'd1);
        for (int c = 1; c <= 4; c++) begin
            @(negedge CLK); #1;
            chk($sformatf("t3_hold_c%0d", c),    32'(bitstr_out), 32'h5555);
            chk($sformatf("t3_hold_rd_c%0d", c), 32'(fifo_rd),    32'd0);
        end
        @(negedge CLK);
        push(mk(1'b1, 15'd1, 16'h6666));
        #1;
        chk("t3_hold_c5",    32'(bitstr_out), 32'h5555);
        chk("t3_resume_rd",  32'(fifo_rd),    32'd1);
        @(negedge CLK); #1;
        chk("t3_w2_c6", 32'(bitstr_out), 32'h6666);
        @(negedge CLK); #1;
        chk("t3_w2_c7", 32'(bitstr_out), 32'h6666);
        @(negedge CLK); #1;
        chk("t3_dend",  32'(D_END),        32'd1);
        chk("t3_words", 32'(words_played), 32'd2);
`ifdef NMR_BSTRM_UFLOW_EN
        chk("t3_ufl",   32'(ufl),          32'd1);
`endif
        release_seq("t3");

        // STOP at cycle 10 of a dwell-100 word
        push(mk(1'b0, 15'd100, 16'h7777));
        push(mk(1'b1, 15'd0,   16'h8888));
        START = 1'b1;
        @(negedge CLK);
        for (int c = 1; c <= 10; c++) begin
            @(negedge CLK); #1;
            chk($sformatf("t4_bits_c%0d", c), 32'(bitstr_out), 32'h7777);
        end
        STOP = 1'b1;
        #1;
        chk("t4_stop_rd", 32'(fifo_rd), 32'd0);
        @(negedge CLK); #1;
        chk("t4_abort_bits",  32'(bitstr_out),   32'(IDLE_W));
        chk("t4_abort_dend",  32'(D_END),        32'd0);
        chk("t4_abort_busy",  32'(busy),         32'd0);
        chk("t4_abort_rd",    32'(fifo_rd),      32'd0);
        chk("t4_abort_words", 32'(words_played), 32'd1);
        STOP = 1'b0;
        @(negedge CLK); #1;
        chk("t4_rel_hold_busy", 32'(busy), 32'd0);
        START = 1'b0;
        @(negedge CLK);
        // START and STOP together in IDLE: ignored until START falls
        START = 1'b1;
        STOP  = 1'b1;
        @(negedge CLK); #1;
        chk("t4_both_busy", 32'(busy),    32'd0);
        chk("t4_both_rd",   32'(fifo_rd), 32'd0);
        STOP = 1'b0;
        @(negedge CLK); #1;
        chk("t4_start_only_busy", 32'(busy), 32'd0);
        START = 1'b0;
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK); #1;
        chk("t4_rearm_rd",    32'(fifo_rd),      32'd1);
        chk("t4_rearm_words", 32'(words_played), 32'd0);
        @(negedge CLK); #1;
        chk("t4_w2_bits", 32'(bitstr_out), 32'h8888);
        @(negedge CLK); #1;
        chk("t4_dend", 32'(D_END), 32'd1);
        release_seq("t4");

        // Asynchronous reset during RUN
        push(mk(1'b0, 15'd5, 16'h9999));
        push(mk(1'b1, 15'd0, 16'hAAAA));
        START = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        @(negedge CLK); #1;
        chk("t5_run_bits", 32'(bitstr_out), 32'h9999);
        RST_n = 1'b0;
        #1;
        chk("t5_rst_bits",  32'(bitstr_out),   32'(IDLE_W));
        chk("t5_rst_dend",  32'(D_END),        32'd0);
        chk("t5_rst_rd",    32'(fifo_rd),      32'd0);
        chk("t5_rst_busy",  32'(busy),         32'd0);
        chk("t5_rst_words", 32'(words_played), 32'd0);
        chk("t5_fifo_kept", 32'(wr_ptr - rd_ptr), 32'd1);
        @(negedge CLK);
        RST_n = 1'b1;
        @(negedge CLK); #1;
        chk("t5_rearm_words", 32'(words_played), 32'd0);
        chk("t5_rearm_busy",  32'(busy),         32'd1);
        @(negedge CLK); #1;
        chk("t5_bits",  32'(bitstr_out),   32'hAAAA);
        chk("t5_words", 32'(words_played), 32'd1);
        @(negedge CLK); #1;
        chk("t5_dend", 32'(D_END), 32'd1);
        release_seq("t5");

        chk("bad_pops", 32'(bad_pops), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
